// File: rtl/funct_generator_pkg.sv
// Shared types, defaults and helpers for the function-generator delay line.
package funct_generator_pkg;

    localparam int unsigned DefaultDataWidth = 8;
    localparam int unsigned DefaultDepth     = 4;
    localparam int unsigned MaxDepth         = 64;

    typedef logic [DefaultDataWidth-1:0] sample_t;

    // Out-of-range selects (non-power-of-two depths) fall back to the last stage.
    function automatic int unsigned clamp_tap(input int unsigned sel, input int unsigned depth);
        return (sel > depth - 1) ? depth - 1 : sel;
    endfunction

    function automatic int unsigned count_ones(input logic [MaxDepth-1:0] bits);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MaxDepth; i++) begin
            n += 32'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/funct_generator_delay_stage.sv
// One data+valid register of the delay chain with rst > clrh > enh > hold priority.
module funct_generator_delay_stage
    import funct_generator_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = DefaultDataWidth,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clrh,
    input  logic                  enh,
    input  logic [DATA_WIDTH-1:0] d_i,
    input  logic                  valid_i,
    output logic [DATA_WIDTH-1:0] q_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  vld_q, vld_d;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (clrh) begin
            data_d = '0;
            vld_d  = 1'b0;
        end else if (enh) begin
            data_d = d_i;
            vld_d  = valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RESET_VALUE;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q_o     = data_q;
    assign valid_o = vld_q;

endmodule

// File: rtl/funct_generator_delay_line.sv
// DEPTH-stage delay line with valid tracking, stall, clear and occupancy count.
// Define FG_DELAY_TAP_EN to make tap_sel select the output stage; otherwise the last stage is used.
module funct_generator_delay_line
    import funct_generator_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = DefaultDataWidth,
    parameter int unsigned           DEPTH       = DefaultDepth,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    localparam int unsigned          TAP_W       = $clog2(DEPTH),
    localparam int unsigned          CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clrh,
    input  logic                  enh,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic [TAP_W-1:0]      tap_sel,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  valid_o,
    output logic [CNT_W-1:0]      occupancy
);

    logic [DATA_WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0]      stage_vld;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [DATA_WIDTH-1:0] din;
        logic                  vin;

        if (k == 0) begin : g_head
            assign din = d;
            assign vin = valid_i;
        end else begin : g_body
            assign din = stage_data[k-1];
            assign vin = stage_vld[k-1];
        end

        funct_generator_delay_stage #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .clrh    (clrh),
            .enh     (enh),
            .d_i     (din),
            .valid_i (vin),
            .q_o     (stage_data[k]),
            .valid_o (stage_vld[k])
        );
    end

    logic [CNT_W-1:0] occ_q, occ_d;

    // A sample entering while another leaves keeps the count unchanged.
    always_comb begin
        occ_d = occ_q;
        if (clrh) begin
            occ_d = '0;
        end else if (enh) begin
            case ({valid_i, stage_vld[DEPTH-1]})
                2'b10:   occ_d = occ_q + CNT_W'(1);
                2'b01:   occ_d = occ_q - CNT_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // The counter must always agree with the valid bits actually in the chain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (32'(occ_q) <= DEPTH);
            assert (32'(occ_q) == count_ones(MaxDepth'(stage_vld)));
        end
    end

    logic [TAP_W-1:0] eff;

`ifdef FG_DELAY_TAP_EN
    assign eff = TAP_W'(clamp_tap(32'(tap_sel), DEPTH));
`else
    logic unused_tap_sel;
    assign unused_tap_sel = ^tap_sel;
    assign eff = TAP_W'(DEPTH - 1);
`endif

    assign q         = stage_data[eff];
    assign valid_o   = stage_vld[eff];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_funct_generator_delay_line.sv
// Directed bench for funct_generator_delay_line: DEPTH=4 (RESET_VALUE=A5) and DEPTH=3 instances.
module tb_funct_generator_delay_line;

`ifdef FG_DELAY_TAP_EN
    localparam bit TapEn = 1'b1;
`else
    localparam bit TapEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       clr4, en4, v4;
    logic [7:0] d4;
    logic [1:0] tap4;
    logic [7:0] q4;
    logic       vo4;
    logic [2:0] occ4;

    logic       clr3, en3, v3;
    logic [7:0] d3;
    logic [1:0] tap3;
    logic [7:0] q3;
    logic       vo3;
    logic [1:0] occ3;

    int n_checks = 0;
    int n_fail   = 0;

    funct_generator_delay_line #(
        .DATA_WIDTH  (8),
        .DEPTH       (4),
        .RESET_VALUE (8'hA5)
    ) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .clrh      (clr4),
        .enh       (en4),
        .valid_i   (v4),
        .d         (d4),
        .tap_sel   (tap4),
        .q         (q4),
        .valid_o   (vo4),
        .occupancy (occ4)
    );

    funct_generator_delay_line #(
        .DATA_WIDTH  (8),
        .DEPTH       (3),
        .RESET_VALUE (8'h00)
    ) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .clrh      (clr3),
        .enh       (en3),
        .valid_i   (v3),
        .d         (d3),
        .tap_sel   (tap3),
        .q         (q3),
        .valid_o   (vo3),
        .occupancy (occ3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_q3   [6];
    logic       exp_v3   [6];
    logic [1:0] exp_occ3 [6];

    initial begin
        exp_q3   = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        exp_v3   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_occ3 = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};

        rst = 1'b1;
        clr4 = 1'b0; en4 = 1'b0; v4 = 1'b0; d4 = 8'h00; tap4 = 2'd3;
        clr3 = 1'b0; en3 = 1'b0; v3 = 1'b0; d3 = 8'h00; tap3 = 2'd3;

        // Reset
        tick();
        tick();
        check("reset_q", 32'(q4), 32'h A5);
        check("reset_valid", 32'(vo4), 32'd0);
        check("reset_occ", 32'(occ4), 32'd0);
        check("reset_q_d3", 32'(q3), 32'h00);

        // Fixed delay of 4 edges
        rst = 1'b0;
        en4 = 1'b1; v4 = 1'b1;
        d4 = 8'h11; tick();
        d4 = 8'h22; tick();
        d4 = 8'h33; tick();
        check("fill3_q", 32'(q4), 32'h A5);
        check("fill3_valid", 32'(vo4), 32'd0);
        check("fill3_occ", 32'(occ4), 32'd3);
        d4 = 8'h44; tick();
        check("delay_q", 32'(q4), 32'h11);
        check("delay_valid", 32'(vo4), 32'd1);
        check("delay_occ", 32'(occ4), 32'd4);
        d4 = 8'h55; tick();
        check("stream_q", 32'(q4), 32'h22);
        check("stream_occ", 32'(occ4), 32'd4);

        // Stall for 3 cycles
        en4 = 1'b0; d4 = 8'h66;
        tick();
        tick();
        tick();
        check("stall_q", 32'(q4), 32'h22);
        check("stall_valid", 32'(vo4), 32'd1);
        check("stall_occ", 32'(occ4), 32'd4);
        en4 = 1'b1;
        tick();
        check("resume_q", 32'(q4), 32'h33);

        // Chain now 66,55,44,33 in stages 0..3; tap change is immediate
        en4 = 1'b0;
        tap4 = 2'd0; #1;
        check("tap0_q", 32'(q4), TapEn ? 32'h66 : 32'h33);
        tap4 = 2'd1; #1;
        check("tap1_q", 32'(q4), TapEn ? 32'h55 : 32'h33);
        tap4 = 2'd3; #1;
        check("tap3_q", 32'(q4), 32'h33);

        // Bubble in, valid out -> occupancy 3
        en4 = 1'b1; v4 = 1'b0; d4 = 8'h00;
        tick();
        check("drain_occ", 32'(occ4), 32'd3);
        check("drain_q", 32'(q4), 32'h44);

        // Clear wins over shift
        clr4 = 1'b1; v4 = 1'b1; d4 = 8'hFF;
        tick();
        clr4 = 1'b0; en4 = 1'b0;
        check("clear_q", 32'(q4), 32'h00);
        check("clear_valid", 32'(vo4), 32'd0);
        check("clear_occ", 32'(occ4), 32'd0);
        tap4 = 2'd0; #1;
        check("clear_stage0", 32'(q4), 32'h00);

        // First shift after clear starts from empty
        en4 = 1'b1; v4 = 1'b1; d4 = 8'h77;
        tick();
        check("post_clear_occ", 32'(occ4), 32'd1);
        check("post_clear_q", 32'(q4), TapEn ? 32'h77 : 32'h00);
        check("post_clear_valid", 32'(vo4), TapEn ? 32'd1 : 32'd0);

        // Reset mid-stream reloads RESET_VALUE
        rst = 1'b1;
        tick();
        rst = 1'b0; en4 = 1'b0;
        check("midrst_q", 32'(q4), 32'h A5);
        check("midrst_valid", 32'(vo4), 32'd0);
        check("midrst_occ", 32'(occ4), 32'd0);

        // DEPTH=3, tap_sel=3 clamps to 2; alternating bubbles
        en3 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d3 = 8'(i + 1);
            v3 = ~i[0];
            tick();
            check($sformatf("bub_occ%0d", i), 32'(occ3), 32'(exp_occ3[i]));
            check($sformatf("bub_q%0d", i), 32'(q3), 32'(exp_q3[i]));
            check($sformatf("bub_v%0d", i), 32'(vo3), 32'(exp_v3[i]));
        end
        en3 = 1'b0;
        tap3 = 2'd0; #1;
        check("d3_tap0_q", 32'(q3), TapEn ? 32'h06 : 32'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
